// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed 7-segment driver for two 8-bit countdown values.
// A sequential double-dabble engine converts both values in parallel; the scan shows NUM1 then NUM2.
module seg7_scan_display #(
  parameter int SCAN_DIV      = 1,
  parameter bit COMMON_ANODE  = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clock1KHz,
  input  logic       rst,
  input  logic [7:0] NUM1,
  input  logic [7:0] NUM2,
  output logic [6:0] SEG,
  output logic [3:0] AN,
  output logic       OVF1,
  output logic       OVF2,
  output logic       BUSY
);

  // state | meaning
  // IDLE  | compare inputs against shadows, start a conversion on mismatch
  // SHIFT | one add-3/shift step per edge, eight steps
  // DONE  | load both channels' digits and overflow flags together
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] SEG_OFF = COMMON_ANODE ? 7'b1111111 : 7'b0000000;
  localparam logic [3:0] AN_OFF  = COMMON_ANODE ? 4'b1111 : 4'b0000;

  state_t      state;
  logic [7:0]  shadow1, shadow2;
  logic [19:0] sh1, sh2;
  logic [2:0]  iter;
  logic [3:0]  tens1, ones1, tens2, ones2;

  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic [1:0]    nxt_idx;
  logic [3:0]    sel_digit;
  logic          sel_tens;
  logic          sel_ovf;
  logic [6:0]    pat;
  logic [3:0]    an_hi;

  // {bcd hundreds, tens, ones, binary}; adjust every BCD nibble then shift
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    for (int n = 0; n < 3; n++) begin
      if (t[8+4*n +: 4] >= 4'd5) t[8+4*n +: 4] = t[8+4*n +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  // Active-high {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_hi(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  always_ff @(posedge clock1KHz or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shadow1 <= 8'd0;
      shadow2 <= 8'd0;
      sh1     <= 20'd0;
      sh2     <= 20'd0;
      iter    <= 3'd0;
      tens1   <= 4'd0;
      ones1   <= 4'd0;
      tens2   <= 4'd0;
      ones2   <= 4'd0;
      OVF1    <= 1'b0;
      OVF2    <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (NUM1 != shadow1 || NUM2 != shadow2) begin
            sh1     <= {12'd0, NUM1};
            sh2     <= {12'd0, NUM2};
            shadow1 <= NUM1;
            shadow2 <= NUM2;
            iter    <= 3'd0;
            BUSY    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          sh1  <= dd_step(sh1);
          sh2  <= dd_step(sh2);
          iter <= iter + 3'd1;
          if (iter == 3'd7) state <= DONE;
        end
        DONE: begin
          tens1 <= sh1[15:12];
          ones1 <= sh1[11:8];
          OVF1  <= (sh1[19:16] != 4'd0);
          tens2 <= sh2[15:12];
          ones2 <= sh2[11:8];
          OVF2  <= (sh2[19:16] != 4'd0);
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Pattern for the digit about to be lit, so AN and SEG change on the same edge
  always_comb begin
    nxt_idx   = idx + 2'd1;
    sel_digit = 4'd0;
    sel_tens  = 1'b0;
    sel_ovf   = 1'b0;
    case (nxt_idx)
      2'd0: begin sel_digit = tens1; sel_tens = 1'b1; sel_ovf = OVF1; end
      2'd1: begin sel_digit = ones1; sel_tens = 1'b0; sel_ovf = OVF1; end
      2'd2: begin sel_digit = tens2; sel_tens = 1'b1; sel_ovf = OVF2; end
      default: begin sel_digit = ones2; sel_tens = 1'b0; sel_ovf = OVF2; end
    endcase
    if (sel_ovf)
      pat = 7'b1000000;
    else if (BLANK_LEADING && sel_tens && sel_digit == 4'd0)
      pat = 7'b0000000;
    else
      pat = seg_hi(sel_digit);
    an_hi = 4'b0001 << nxt_idx;
  end

  always_ff @(posedge clock1KHz or negedge rst) begin
    if (!rst) begin
      div <= '0;
      idx <= 2'd3;
      AN  <= AN_OFF;
      SEG <= SEG_OFF;
    end else if (div == DW'(SCAN_DIV - 1)) begin
      div <= '0;
      idx <= nxt_idx;
      AN  <= COMMON_ANODE ? ~an_hi : an_hi;
      SEG <= COMMON_ANODE ? ~pat : pat;
    end else begin
      div <= div + DW'(1);
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: default instance plus a SCAN_DIV=4 instance.
module tb_seg7_scan_display;

  logic       clk;
  logic       rst, rst4;
  logic [7:0] num1, num2, n41, n42;
  logic [6:0] seg, seg4;
  logic [3:0] an, an4;
  logic       ovf1, ovf2, busy, ovf41, ovf42, busy4;

  int checks = 0;
  int errors = 0;
  logic [6:0] cap [4];

  seg7_scan_display dut (
    .clock1KHz(clk), .rst(rst), .NUM1(num1), .NUM2(num2),
    .SEG(seg), .AN(an), .OVF1(ovf1), .OVF2(ovf2), .BUSY(busy)
  );

  seg7_scan_display #(.SCAN_DIV(4)) dut4 (
    .clock1KHz(clk), .rst(rst4), .NUM1(n41), .NUM2(n42),
    .SEG(seg4), .AN(an4), .OVF1(ovf41), .OVF2(ovf42), .BUSY(busy4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Record SEG for each digit over one full scan of the default instance
  task automatic grab;
    for (int i = 0; i < 4; i++) cap[i] = 7'bx;
    for (int k = 0; k < 4; k++) begin
      tick;
      case (an)
        4'b1110: cap[0] = seg;
        4'b1101: cap[1] = seg;
        4'b1011: cap[2] = seg;
        4'b0111: cap[3] = seg;
        default: ;
      endcase
    end
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    tick;
    while (busy && n < 40) begin
      tick;
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_an [5];
    logic [6:0] exp_seg [5];
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    exp_seg = '{7'b1111111, 7'b1000000, 7'b1111111, 7'b1000000, 7'b1111111};
    rst = 1'b0; num1 = 8'd0; num2 = 8'd0;
    #23;
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: an=%b seg=%b busy=%b, required 1111 1111111 0", an, seg, busy);
    end
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (an !== exp_an[i] || seg !== exp_seg[i] || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_scan[%0d]: an=%b seg=%b busy=%b, required %b %b 0",
                 i, an, seg, busy, exp_an[i], exp_seg[i]);
      end
    end
  endtask

  task automatic test_conversion;
    int n;
    logic [6:0] exp [4];
    logic [6:0] old_exp;
    exp = '{7'b0110000, 7'b1000000, 7'b0100100, 7'b0010010};
    num1 = 8'd30; num2 = 8'd25;
    n = 0;
    tick;
    while (busy && n < 20) begin
      n++;
      tick;
    end
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL busy_len: busy cycles=%0d, required 9", n);
    end
    // DONE edge still shows the previous all-zero digits
    old_exp = (an == 4'b1110 || an == 4'b1011) ? 7'b1111111 : 7'b1000000;
    checks++;
    if (seg !== old_exp) begin
      errors++;
      $display("FAIL latency: seg=%b at DONE edge, required old %b", seg, old_exp);
    end
    grab;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap[i] !== exp[i]) begin
        errors++;
        $display("FAIL conv_30_25 digit%0d: seg=%b, required %b", i, cap[i], exp[i]);
      end
    end
    checks++;
    if (ovf1 !== 1'b0 || ovf2 !== 1'b0) begin
      errors++;
      $display("FAIL conv_ovf: ovf1=%b ovf2=%b, required 0 0", ovf1, ovf2);
    end
  endtask

  task automatic test_blanking;
    num1 = 8'd7;
    wait_idle;
    grab;
    checks++;
    if (cap[0] !== 7'b1111111 || cap[1] !== 7'b1111000) begin
      errors++;
      $display("FAIL blank_7: d0=%b d1=%b, required 1111111 1111000", cap[0], cap[1]);
    end
    checks++;
    if (cap[2] !== 7'b0100100 || cap[3] !== 7'b0010010) begin
      errors++;
      $display("FAIL blank_7_ch2: d2=%b d3=%b, required 0100100 0010010", cap[2], cap[3]);
    end
    num1 = 8'd99;
    wait_idle;
    grab;
    checks++;
    if (cap[0] !== 7'b0010000 || cap[1] !== 7'b0010000) begin
      errors++;
      $display("FAIL show_99: d0=%b d1=%b, required 0010000 0010000", cap[0], cap[1]);
    end
  endtask

  task automatic test_overflow;
    num2 = 8'd150;
    wait_idle;
    grab;
    checks++;
    if (ovf2 !== 1'b1 || ovf1 !== 1'b0 || cap[2] !== 7'b0111111 || cap[3] !== 7'b0111111) begin
      errors++;
      $display("FAIL ovf_150: ovf1=%b ovf2=%b d2=%b d3=%b, required 0 1 0111111 0111111",
               ovf1, ovf2, cap[2], cap[3]);
    end
    checks++;
    if (cap[0] !== 7'b0010000 || cap[1] !== 7'b0010000) begin
      errors++;
      $display("FAIL ovf_ch1: d0=%b d1=%b, required 0010000 0010000", cap[0], cap[1]);
    end
    num2 = 8'd20;
    wait_idle;
    grab;
    checks++;
    if (ovf2 !== 1'b0 || cap[2] !== 7'b0100100 || cap[3] !== 7'b1000000) begin
      errors++;
      $display("FAIL ovf_clear_20: ovf2=%b d2=%b d3=%b, required 0 0100100 1000000",
               ovf2, cap[2], cap[3]);
    end
  endtask

  task automatic test_back_to_back;
    num1 = 8'd30;
    tick;
    for (int i = 0; i < 3; i++) tick;
    num1 = 8'd29;
    for (int i = 0; i < 6; i++) tick;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: busy=%b after first DONE, required 0", busy);
    end
    tick;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b one cycle after DONE, required 1", busy);
    end
    grab;
    checks++;
    if (cap[0] !== 7'b0110000 || cap[1] !== 7'b1000000) begin
      errors++;
      $display("FAIL b2b_first: d0=%b d1=%b, required 0110000 1000000", cap[0], cap[1]);
    end
    wait_idle;
    grab;
    checks++;
    if (cap[0] !== 7'b0100100 || cap[1] !== 7'b0010000) begin
      errors++;
      $display("FAIL b2b_second: d0=%b d1=%b, required 0100100 0010000", cap[0], cap[1]);
    end
  endtask

  task automatic test_scan_div_and_async_reset;
    n41 = 8'd0; n42 = 8'd0;
    rst4 = 1'b0;
    #12;
    @(negedge clk) rst4 = 1'b1;
    for (int i = 0; i < 3; i++) tick;
    checks++;
    if (an4 !== 4'b1111) begin
      errors++;
      $display("FAIL div4_pre: an=%b after 3 edges, required 1111", an4);
    end
    tick;
    checks++;
    if (an4 !== 4'b1110 || seg4 !== 7'b1111111) begin
      errors++;
      $display("FAIL div4_first: an=%b seg=%b, required 1110 1111111", an4, seg4);
    end
    for (int i = 0; i < 3; i++) tick;
    checks++;
    if (an4 !== 4'b1110) begin
      errors++;
      $display("FAIL div4_hold: an=%b, required 1110", an4);
    end
    tick;
    checks++;
    if (an4 !== 4'b1101 || seg4 !== 7'b1000000) begin
      errors++;
      $display("FAIL div4_next: an=%b seg=%b, required 1101 1000000", an4, seg4);
    end
    n41 = 8'd42;
    tick;
    tick;
    tick;
    checks++;
    if (busy4 !== 1'b1) begin
      errors++;
      $display("FAIL div4_shift: busy=%b, required 1", busy4);
    end
    #1 rst4 = 1'b0;
    #1;
    checks++;
    if (an4 !== 4'b1111 || seg4 !== 7'b1111111 || busy4 !== 1'b0 || ovf41 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: an=%b seg=%b busy=%b ovf1=%b, required 1111 1111111 0 0",
               an4, seg4, busy4, ovf41);
    end
  endtask

  initial begin
    rst = 1'b0; rst4 = 1'b0;
    num1 = 8'd0; num2 = 8'd0; n41 = 8'd0; n42 = 8'd0;
    test_reset;
    test_conversion;
    test_blanking;
    test_overflow;
    test_back_to_back;
    test_scan_div_and_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Downstream consumer of the traffic-light controller's two 8-bit countdown values (NUM1, NUM2).
- Converts each value to two BCD digits with a sequential double-dabble engine.
- Time-multiplexes four 7-segment digits on the 1 kHz clock: NUM1 tens/ones, then NUM2 tens/ones.
- Drives the board's shared segment bus and digit anodes.

Parameters:
- SCAN_DIV, 1: clock1KHz cycles each digit stays lit (≥1).
- COMMON_ANODE, 1: 1 = SEG and AN active-low; 0 = both active-high.
- BLANK_LEADING, 1: 1 = tens digit of 0 is blanked.

Ports:
- clock1KHz  in  1: only clock; all logic on rising edge.
- rst  in  1: asynchronous, active-low reset.
- NUM1  in  8: light-1 countdown, unsigned binary.
- NUM2  in  8: light-2 countdown, unsigned binary.
- SEG  out  7: {g,f,e,d,c,b,a}, registered.
- AN  out  4: one-hot digit enable, registered. AN[0]=NUM1 tens, AN[1]=NUM1 ones, AN[2]=NUM2 tens, AN[3]=NUM2 ones.
- OVF1  out  1: NUM1 value being displayed is >99.
- OVF2  out  1: NUM2 value being displayed is >99.
- BUSY  out  1: conversion in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM = IDLE; shadow copies of NUM1/NUM2 = 0.
  - Display digit registers = 0; OVF1 = OVF2 = 0; BUSY = 0.
  - Scan index = 3; divider = 0.
  - AN and SEG all off: 4'b1111 / 7'b1111111 when COMMON_ANODE=1.
- Conversion FSM, states IDLE, SHIFT, DONE:
  - IDLE: if NUM1 ≠ shadow1 or NUM2 ≠ shadow2 at an edge, capture both inputs into the shift registers and shadows, clear the iteration counter, go to SHIFT.
  - SHIFT: each edge, add 3 to every BCD nibble ≥5, then shift left 1 (both channels in parallel, 12-bit BCD each). After the 8th shift go to DONE.
  - DONE: one edge; atomically load tens/ones digit registers and OVF flags for both channels; go to IDLE.
  - BUSY = (state ≠ IDLE): high for exactly 9 cycles per conversion.
  - Latency: new digits appear at the 10th edge after the edge that detected the change.
  - Input changes during SHIFT/DONE are ignored. IDLE re-detects the mismatch on the next edge and reconverts immediately; no value is lost permanently.
  - Reset mid-conversion aborts the conversion; display returns to reset values.
- Overflow: hundreds nibble ≠ 0 → OVF set; both digits of that channel show dash (segment g only). Blanking does not apply.
- Scan:
  - Divider counts 0..SCAN_DIV-1. At wrap, index increments mod 4 (3→0), and AN/SEG load on that same edge for the new index, so they are always coherent.
  - After reset, the first digit (index 0) lights after SCAN_DIV edges.
  - Exactly one AN bit is active after that first edge.
- Leading-zero blanking: tens digit = 0 and BLANK_LEADING=1 → all segments off. Ones digit is never blanked.
- Segment polarity:
  - COMMON_ANODE=1: SEG and AN are the inversion of the active-high patterns.
  - Active-low codes: 0=1000000, 2=0100100, 3=0110000, 5=0010010, 7=1111000, 9=0010000, dash=0111111, blank=1111111.
- Display values update only at DONE. The scan never shows a half-updated pair.

Test Plan:
1. Reset, defaults (SCAN_DIV=1, CA, blanking): hold rst=0 → AN=1111, SEG=1111111, BUSY=0. Release with NUM1=NUM2=0 → BUSY stays 0. Edge 1: AN=1110, SEG=1111111 (blank). Edge 2: AN=1101, SEG=1000000. Sequence then repeats 1011, 0111, 1110.
2. NUM1=30, NUM2=25 applied → BUSY=1 for 9 cycles. From the 10th edge: digit0=0110000, digit1=1000000, digit2=0100100, digit3=0010010; OVF1=OVF2=0.
3. NUM1=7 → digit0 blank 1111111, digit1=1111000. Then NUM1=99 → digit0=digit1=0010000.
4. NUM2=150 → OVF2=1, digits 2 and 3 = 0111111. Then NUM2=20 → OVF2=0, digits 2/3 = 0100100 / 1000000.
5. NUM1 30→29 on the 4th SHIFT cycle → first DONE shows 30. Immediate second conversion; 29 shown 10 edges later. BUSY drops for exactly one cycle between the conversions.
6. SCAN_DIV=4 → each AN value held 4 cycles. Assert rst mid-SHIFT → AN=1111, SEG=1111111, BUSY=0 immediately, without a clock edge.
